if_stage: RTL and testbench

// - Instruction-fetch stage; sits directly upstream of the decode stage and feeds it {instr, pc}.
// - Owns the PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
// - Buffers returned words in a small in-order FIFO and presents one instruction per cycle to decode.
// - Accepts redirects from branch/jump resolution and squashes wrong-path fetches.

---
 rtl/if_stage_if.sv | 19 +
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The master side issues req/addr; the slave side answers with gnt/rvalid/rdata.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over imem, buffers words for decode.
// Optional IF_PERF_CNT_EN adds fetch_cnt_o / squash_cnt_o performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    if_stage_if.master        imem,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic              valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       squash_cnt_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = 8;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [DW-1:0] discard;
    logic [31:0]   pc_q    [FIFO_DEPTH];
    logic [31:0]   instr_q [FIFO_DEPTH];

    logic          grant;
    logic          drop;
    logic          push;
    logic          pop;
    logic [CW:0]   reserved;
    logic [31:0]   resp_pc;
    logic [DW-1:0] inflight;

    assign reserved  = {1'b0, count} + {1'b0, outstanding};
    assign imem.req  = !rst && !redirect_i && (reserved < DEPTH_W);
    assign imem.addr = {fetch_pc[31:2], 2'b00};

    assign grant = imem.req && imem.gnt;
    assign drop  = imem.rvalid && (discard != '0);
    assign push  = imem.rvalid && (discard == '0);
    assign pop   = valid_o && !stall_i;

    // Live requests are contiguous, so the oldest one sits outstanding words behind fetch_pc.
    assign resp_pc  = fetch_pc - 32'({outstanding, 2'b00});
    assign inflight = discard + DW'(outstanding) - DW'(imem.rvalid);

    assign valid_o = (count != '0);
    assign instr_o = valid_o ? instr_q[rd_ptr] : NOP_INSTR;
    assign pc_o    = valid_o ? pc_q[rd_ptr] : RESET_PC;

    always_ff @(posedge clk) begin
        if (rst || redirect_i) begin
            fetch_pc    <= rst ? RESET_PC : {redirect_pc_i[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= inflight;
        end else begin
            if (grant)
                fetch_pc <= fetch_pc + 32'd4;
            if (drop)
                discard <= discard - DW'(1);
            if (push) begin
                pc_q[wr_ptr]    <= resp_pc;
                instr_q[wr_ptr] <= imem.rdata;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            outstanding <= outstanding + CW'(grant) - CW'(push);
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_o  <= '0;
            squash_cnt_o <= '0;
        end else begin
            if (pop && !redirect_i)
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (imem.rvalid && (redirect_i || drop))
                squash_cnt_o <= squash_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cycle table for fetch/stall, hand sequences for
// redirect, PC wrap and mid-run reset.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] squash_cnt_o;
`endif

    if_stage_if bus();

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (bus.master),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .squash_cnt_o  (squash_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs [14];
    int   tests;
    int   fails;

    function automatic vec_t mk(logic st, logic g, logic rv, logic [31:0] rd,
                                logic rq, logic [31:0] ad, logic vl,
                                logic [31:0] p, logic [31:0] ins);
        vec_t v;
        v.stall = st; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.req = rq; v.addr = ad; v.valid = vl; v.pc = p; v.instr = ins;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic g, input logic rv, input logic [31:0] rdat);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        bus.gnt       = g;
        bus.rvalid    = rv;
        bus.rdata     = rdat;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        // Cycle table after reset: gnt held, rvalid one cycle after grant, then a 5-cycle stall.
        vecs[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h00, 1'b0, 32'h0,  NOP);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 32'hA000_0000, 1'b1, 32'h04, 1'b0, 32'h0,  NOP);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 32'hA000_0004, 1'b0, 32'h08, 1'b1, 32'h0,  32'hA000_0000);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h08, 1'b1, 32'h4,  32'hA000_0004);
        vecs[4]  = mk(1'b0, 1'b1, 1'b1, 32'hA000_0008, 1'b1, 32'h0C, 1'b0, 32'h0,  NOP);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 32'hA000_000C, 1'b0, 32'h10, 1'b1, 32'h8,  32'hA000_0008);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10, 1'b1, 32'hC,  32'hA000_000C);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h10, 1'b1, 32'hC,  32'hA000_000C);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 32'hA000_0010, 1'b0, 32'h14, 1'b1, 32'hC,  32'hA000_000C);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h14, 1'b1, 32'hC,  32'hA000_000C);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h14, 1'b1, 32'hC,  32'hA000_000C);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h14, 1'b1, 32'hC,  32'hA000_000C);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h14, 1'b1, 32'h10, 32'hA000_0010);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h14, 1'b0, 32'h0,  NOP);

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst.req",   32'(bus.req), 32'h0);
        chk("rst.valid", 32'(valid_o), 32'h0);
        chk("rst.instr", instr_o, NOP);
        chk("rst.pc",    pc_o, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].stall, 1'b0, 32'h0, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            chk($sformatf("v%0d.req", i),   32'(bus.req),  32'(vecs[i].req));
            chk($sformatf("v%0d.addr", i),  bus.addr,      vecs[i].addr);
            chk($sformatf("v%0d.valid", i), 32'(valid_o),  32'(vecs[i].valid));
            chk($sformatf("v%0d.pc", i),    pc_o,          vecs[i].pc);
            chk($sformatf("v%0d.instr", i), instr_o,       vecs[i].instr);
            @(negedge clk);
        end

        // Redirect to an unaligned target with two requests in flight.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r1.addr", bus.addr, 32'h14);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r2.addr", bus.addr, 32'h18);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0);
        chk("r3.req", 32'(bus.req), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0014);
        chk("r4.req",  32'(bus.req), 32'h1);
        chk("r4.addr", bus.addr, 32'h100);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0018);
        chk("r5.valid", 32'(valid_o), 32'h0);
        chk("r5.addr",  bus.addr, 32'h104);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB000_0100);
        chk("r6.valid", 32'(valid_o), 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("r7.valid", 32'(valid_o), 32'h1);
        chk("r7.pc",    pc_o, 32'h100);
        chk("r7.instr", instr_o, 32'hB000_0100);
`ifdef IF_PERF_CNT_EN
        chk("r7.squash", squash_cnt_o, 32'd2);
`endif
        @(negedge clk);

        // Redirect beats stall, then the PC wraps past 0xFFFF_FFFC.
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        chk("w1.valid", 32'(valid_o), 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("w2.valid", 32'(valid_o), 32'h0);
        chk("w2.addr",  bus.addr, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000);
        chk("w3.req",  32'(bus.req), 32'h1);
        chk("w3.addr", bus.addr, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("w4.pc",    pc_o, 32'hFFFF_FFFC);
        chk("w4.instr", instr_o, 32'hC000_0000);
        @(negedge clk);

        // Reset with one request in flight: its late response must be dropped.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("s1.addr", bus.addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("s2.req", 32'(bus.req), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0000);
        chk("s3.valid", 32'(valid_o), 32'h0);
        chk("s3.pc",    pc_o, 32'h0);
        chk("s3.instr", instr_o, NOP);
        chk("s3.addr",  bus.addr, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("s4.valid", 32'(valid_o), 32'h0);
        chk("s4.addr",  bus.addr, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hE000_0000);
        chk("s5.valid", 32'(valid_o), 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("s5.squash", squash_cnt_o, 32'd1);
        chk("s5.fetch",  fetch_cnt_o, 32'd0);
`endif
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s6.valid", 32'(valid_o), 32'h1);
        chk("s6.pc",    pc_o, 32'h0);
        chk("s6.instr", instr_o, 32'hE000_0000);
        @(negedge clk);
        chk("s7.valid", 32'(valid_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
